ram_bus_responder: RTL and testbench

RAM_BUS_RESPONDER -- requirements
Module: ram_bus_responder

---
 rtl/ram_bus_responder.sv | 153 +++++++++++++++
 tb/tb_ram_bus_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_responder.sv
// Word-wide bus responder driving an 8-bit asynchronous SRAM, low byte then high byte.
// Optional one-entry last-load cache enabled by defining READ_CACHE_EN.
module ram_bus_responder #(
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  busState,
  input  logic        ramWrite,
  input  logic [15:0] ramAdd,
  input  logic [15:0] din,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic [16:0] sram_addr,
  output logic [7:0]  sram_dq_out,
  input  logic [7:0]  sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES + 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [15:0] r_addr, r_din, r_rdata;
  logic [7:0]  r_lo;
  logic        r_store, r_rvalid;

  logic        w_ready, w_req_st, w_req_ld, w_hit, w_phase_end;
  logic        w_active, w_strobe;
  logic [15:0] w_cdata;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_req_st    = w_ready && (busState == 4'h1) && ramWrite;
  assign w_req_ld    = w_ready && (busState == 4'h2);
  assign w_phase_end = (r_cnt == CNT_LAST);

`ifdef READ_CACHE_EN
  logic        r_cvalid;
  logic [15:0] r_ctag, r_cdata;

  assign w_hit   = w_req_ld && r_cvalid && (r_ctag == ramAdd);
  assign w_cdata = r_cdata;

  // Filled by every SRAM load; stores to the tagged word write through.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cvalid <= 1'b0;
      r_ctag   <= 16'h0000;
      r_cdata  <= 16'h0000;
    end else if ((r_state == S_HI) && w_phase_end && !r_store) begin
      r_cvalid <= 1'b1;
      r_ctag   <= r_addr;
      r_cdata  <= {sram_dq_in, r_lo};
    end else if (w_req_st && r_cvalid && (r_ctag == ramAdd)) begin
      r_cdata  <= din;
    end
  end
`else
  assign w_hit   = 1'b0;
  assign w_cdata = 16'h0000;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_cnt_next = 4'd0;
        if (w_hit)                      w_state_next = S_DONE;
        else if (w_req_st || w_req_ld)  w_state_next = S_LO;
        else                            w_state_next = S_IDLE;
      end
      S_LO: begin
        if (w_phase_end) begin
          w_state_next = S_HI;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt + 4'd1;
        end
      end
      S_HI: begin
        if (w_phase_end) begin
          w_state_next = S_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr   <= 16'h0000;
      r_din    <= 16'h0000;
      r_store  <= 1'b0;
      r_lo     <= 8'h00;
      r_rdata  <= 16'h0000;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_hit) begin
        r_rdata  <= w_cdata;
        r_rvalid <= 1'b1;
      end else if (w_req_st || w_req_ld) begin
        r_addr  <= ramAdd;
        r_din   <= din;
        r_store <= w_req_st;
      end
      // Read data is captured at the end of the final strobe cycle of each phase.
      if ((r_state == S_LO) && w_phase_end && !r_store)
        r_lo <= sram_dq_in;
      if ((r_state == S_HI) && w_phase_end && !r_store) begin
        r_rdata  <= {sram_dq_in, r_lo};
        r_rvalid <= 1'b1;
      end
    end
  end

  assign w_active    = (r_state == S_LO) || (r_state == S_HI);
  assign w_strobe    = w_active && (r_cnt != 4'd0);

  assign busy        = w_active;
  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign sram_ce_n   = ~w_active;
  assign sram_oe_n   = ~(w_strobe && !r_store);
  assign sram_we_n   = ~(w_strobe && r_store);
  assign sram_dq_oe  = w_active && r_store;
  assign sram_addr   = {r_addr, (r_state == S_HI)};
  assign sram_dq_out = (r_state == S_HI) ? r_din[15:8] : r_din[7:0];

endmodule

// File: tb/tb_ram_bus_responder.sv
// Bench for ram_bus_responder: vector table, hand-written multi-cycle sequences and
// randomized traffic checked against a word-level memory and cache model.
module tb_ram_bus_responder;

  localparam int W   = 1;
  localparam int PH  = 2 * (W + 2);
  localparam int LAT = 2 * (W + 2) + 1;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  busState;
  logic        ramWrite;
  logic [15:0] ramAdd, din, rdata;
  logic        rvalid, busy;
  logic [16:0] sram_addr;
  logic [7:0]  sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sram_mem [0:131071];
  logic [15:0] ref_mem  [0:65535];
  bit          c_valid;
  logic [15:0] c_tag;

  typedef struct {
    logic [3:0]  bs;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [13];

  always #5 CLK = ~CLK;

  ram_bus_responder #(.WAIT_STATES(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .busState(busState), .ramWrite(ramWrite),
    .ramAdd(ramAdd), .din(din), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  // Asynchronous SRAM: reads return filler unless enabled, writes land on clock edges.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'hA5;
  always @(posedge CLK)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;

  task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
    end
  endtask

  task automatic idle_inputs();
    busState = 4'h0;
    ramWrite = 1'b0;
    ramAdd   = 16'($urandom);
    din      = 16'($urandom);
  endtask

  task automatic run_access(input logic [3:0] bs, input logic rw, input logic [15:0] addr,
                            input logic [15:0] data, input logic [15:0] exp_data, input string name);
    bit st, ld, hit;
    int n_busy, n_we, n_oe, n_doe, rv_at, rv_cnt;
    logic [15:0] got;
    st = (bs == 4'h1) && rw;
    ld = (bs == 4'h2);
    hit = 1'b0;
`ifdef READ_CACHE_EN
    hit = ld && c_valid && (c_tag == addr);
`endif
    n_busy = 0; n_we = 0; n_oe = 0; n_doe = 0; rv_at = 0; rv_cnt = 0; got = 16'h0;
    @(negedge CLK);
    busState = bs; ramWrite = rw; ramAdd = addr; din = data;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge CLK);
      if (busy) n_busy++;
      if (!sram_we_n) n_we++;
      if (!sram_oe_n) n_oe++;
      if (sram_dq_oe) n_doe++;
      if (rvalid) begin
        rv_cnt++;
        if (rv_at == 0) begin rv_at = k; got = rdata; end
      end
      if (k == 1) idle_inputs();
    end
    chk(name, "busy_cycles", n_busy, (st || (ld && !hit)) ? PH : 0);
    chk(name, "we_cycles",   n_we,   st ? 2 * (W + 1) : 0);
    chk(name, "oe_cycles",   n_oe,   (ld && !hit) ? 2 * (W + 1) : 0);
    chk(name, "dq_oe_cycles", n_doe, st ? PH : 0);
    chk(name, "rvalid_pulses", rv_cnt, ld ? 1 : 0);
    if (ld) begin
      chk(name, "rvalid_latency", rv_at, hit ? 1 : LAT);
      chk(name, "rdata", got, exp_data);
      c_valid = 1'b1;
      c_tag   = addr;
    end
    if (st) ref_mem[addr] = data;
    $display("access %s bs=%h rw=%0d addr=%h din=%h rdata=%h rv_at=%0d", name, bs, rw, addr, data, got, rv_at);
  endtask

  initial begin
    logic [15:0] a;
    int op, rv_cnt;
    vecs[0]  = '{4'h1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1]  = '{4'h2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2]  = '{4'h1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000};
    vecs[3]  = '{4'h2, 1'b0, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[4]  = '{4'h1, 1'b0, 16'h0030, 16'hAAAA, 16'h0000};
    vecs[5]  = '{4'h6, 1'b1, 16'h0030, 16'h5555, 16'h0000};
    vecs[6]  = '{4'h2, 1'b0, 16'h0030, 16'h0000, 16'h0000};
    vecs[7]  = '{4'h1, 1'b1, 16'h0123, 16'h1111, 16'h0000};
    vecs[8]  = '{4'h1, 1'b1, 16'h0456, 16'h2222, 16'h0000};
    vecs[9]  = '{4'h2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[10] = '{4'h2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[11] = '{4'h1, 1'b1, 16'h0010, 16'h1234, 16'h0000};
    vecs[12] = '{4'h2, 1'b0, 16'h0010, 16'h0000, 16'h1234};

    for (int i = 0; i < 131072; i++) sram_mem[i] = 8'h00;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0000;
    c_valid = 1'b0;
    c_tag   = 16'h0;

    RST_N = 1'b0;
    idle_inputs();
    repeat (2) @(negedge CLK);
    chk("reset", "rdata", rdata, 16'h0);
    chk("reset", "rvalid", rvalid, 1'b0);
    chk("reset", "busy", busy, 1'b0);
    chk("reset", "sram_addr", sram_addr, 17'h0);
    chk("reset", "strobes_ce_oe_we", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("reset", "dq_oe_dq_out", {sram_dq_oe, sram_dq_out}, 9'h000);
    RST_N = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_access(vecs[i].bs, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("vec0", "byte_00020", sram_mem[17'h00020], 8'hEF);
        chk("vec0", "byte_00021", sram_mem[17'h00021], 8'hBE);
      end
      if (i == 2) begin
        chk("vec2", "byte_1FFFE", sram_mem[17'h1FFFE], 8'h34);
        chk("vec2", "byte_1FFFF", sram_mem[17'h1FFFF], 8'h12);
      end
    end

    // Back-to-back loads: second presented in DONE; a store presented mid-LO is dropped.
    begin
      int n_we;
      n_we = 0;
      @(negedge CLK);
      busState = 4'h2; ramWrite = 1'b0; ramAdd = 16'h0123;
      for (int k = 1; k <= LAT; k++) begin
        @(negedge CLK);
        if (!sram_we_n) n_we++;
        if (k == 1) begin busState = 4'h1; ramWrite = 1'b1; ramAdd = 16'h0077; din = 16'hDEAD; end
        if (k == 2) idle_inputs();
        if (k == LAT) begin
          chk("b2b_first", "rvalid", rvalid, 1'b1);
          chk("b2b_first", "rdata", rdata, 16'h1111);
          busState = 4'h2; ramAdd = 16'h0456;
        end
      end
      for (int k = 1; k <= LAT; k++) begin
        @(negedge CLK);
        if (!sram_we_n) n_we++;
        if (k == 1) begin
          chk("b2b_second", "busy_no_idle", busy, 1'b1);
          idle_inputs();
        end
        if (k == LAT) begin
          chk("b2b_second", "rvalid", rvalid, 1'b1);
          chk("b2b_second", "rdata", rdata, 16'h2222);
        end
      end
      chk("b2b", "dropped_store_we_cycles", n_we, 0);
      $display("sequence b2b loads 0123->%h 0456 done, mid-LO store we_cycles=%0d", 16'h1111, n_we);
      c_valid = 1'b1;
      c_tag   = 16'h0456;
    end

    // Reset asserted in the middle of a high-byte strobe.
    @(negedge CLK);
    busState = 4'h2; ramWrite = 1'b0; ramAdd = 16'h0789;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge CLK);
      if (k == 1) idle_inputs();
    end
    chk("mid_rst", "pre_oe_n_low", sram_oe_n, 1'b0);
    chk("mid_rst", "pre_addr_hi", sram_addr, {16'h0789, 1'b1});
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst", "strobes_ce_oe_we", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("mid_rst", "busy", busy, 1'b0);
    chk("mid_rst", "sram_addr", sram_addr, 17'h0);
    rv_cnt = 0;
    repeat (3) begin
      @(negedge CLK);
      if (rvalid) rv_cnt++;
    end
    RST_N = 1'b1;
    c_valid = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (rvalid || busy) rv_cnt++;
    end
    chk("mid_rst", "no_rvalid_or_busy", rv_cnt, 0);
    $display("sequence mid_rst done, spurious=%0d", rv_cnt);
    run_access(4'h2, 1'b0, 16'h0789, 16'h0000, ref_mem[16'h0789], "post_rst_load");

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: a = 16'h0010;
        1: a = 16'h0011;
        2: a = 16'hFFFF;
        3: a = 16'h0077;
        default: a = 16'($urandom);
      endcase
      case (op)
        0: run_access(4'h1, 1'b1, a, 16'($urandom), 16'h0, $sformatf("rnd%0d_st", i));
        1: run_access(4'h2, 1'b0, a, 16'($urandom), ref_mem[a], $sformatf("rnd%0d_ld", i));
        2: run_access(4'h1, 1'b0, a, 16'($urandom), 16'h0, $sformatf("rnd%0d_nowr", i));
        default: run_access((($urandom_range(0, 1) == 0) ? 4'h6 : 4'hF), 1'b1, a, 16'($urandom), 16'h0,
                            $sformatf("rnd%0d_other", i));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
